// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin front end for one shared combinational ALU.
// Picks one valid requester per cycle, drives the ALU operand/control bus
// with that requester's fields, and captures the ALU result, zero flag and
// requester ID into a single registered response stage.
//
// Handshake semantics (both sides are strict valid/ready):
//   - A transfer happens on a rising clk edge when valid & ready are both 1.
//   - valid never depends combinationally on ready; ready may depend on valid.
//   - Requesters hold req_a/req_b/req_op stable while req_valid is high and
//     not yet granted; nothing is latched for a request that is not granted.
//   - Once rsp_valid is high, rsp_id/rsp_result/rsp_zero stay stable until
//     the consumer takes them with rsp_ready.
module alu_rr_arbiter #(
  parameter int N    = 64,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [3:0]        alu_ctl,
  input  logic [N-1:0]      alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_result,
  output logic              rsp_zero
);

  // Requester that currently holds highest priority.
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_next;
  logic [IDW-1:0]  winner;
  logic            any_valid;
  logic            can_accept;
  logic            accept;
  logic [NREQ-1:0] grant;

  // Round-robin pick: the valid requester closest to ptr (going upward with
  // wrap) wins. Distance is measured per requester so every index is static.
  always_comb begin
    int off;
    int best;
    off       = 0;
    best      = NREQ;
    winner    = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      off = i - int'(ptr);
      if (off < 0) off = off + NREQ;
      if (req_valid[i] && (off < best)) begin
        best      = off;
        winner    = IDW'(i);
        any_valid = 1'b1;
      end
    end
  end

  // The response stage can take a new result when it is empty or is being
  // drained on this same edge; nothing is granted while reset is held.
  always_comb begin
    can_accept = ~rsp_valid | rsp_ready;
    accept     = any_valid & can_accept & ~reset;
  end

  // One-hot grant towards the requesters.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = accept && (winner == IDW'(i));
    end
  end

  assign req_ready = grant;

  // Operand/control mux to the ALU; the bus is all zeros when nothing is
  // granted. The op code passes through untouched, even undefined codes.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctl = 4'b0000;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_a   = req_a[i*N +: N];
        alu_b   = req_b[i*N +: N];
        alu_ctl = req_op[i*4 +: 4];
      end
    end
  end

  // Priority moves to the requester just after the winner, wrapping to 0.
  always_comb begin
    ptr_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
  end

  // Response stage and priority pointer. A new accept overwrites a result
  // that drains on the same edge, giving one op per cycle throughput.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      ptr        <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= winner;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      ptr        <= ptr_next;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Grant is never more than one requester.
  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));

  // A stalled response holds its payload until taken.
  a_rsp_stable: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) &&
                                   $stable(rsp_result) && $stable(rsp_zero)));

  // No grant goes out while a response is stalled.
  a_no_grant_on_stall: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid && !rsp_ready) |-> (req_ready == '0));

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: a behavioural ALU, a directed vector table,
// hand-written multi-cycle sequences, and a randomized run against a
// reference model with an expected-response queue.
module tb_alu_rr_arbiter;
  localparam int N    = 64;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + N + 1;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ-1:0]   req_ready;
  logic [N-1:0]      alu_a;
  logic [N-1:0]      alu_b;
  logic [3:0]        alu_ctl;
  logic [N-1:0]      alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_result;
  logic              rsp_zero;

  int vectors    = 0;
  int miscompares = 0;

  alu_rr_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctl    (alu_ctl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- external ALU model ----------------
  function automatic logic [N-1:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b1100: return ~(a | b);
      default: return '1;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_a, alu_b, alu_ctl);
    alu_zero   = (alu_result == '0);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [3:0] op);
    req_valid[i]     = v;
    req_a[i*N +: N]  = a;
    req_b[i*N +: N]  = b;
    req_op[i*4 +: 4] = op;
  endtask

  // Round-robin reference: scan from the pointer, wrapping modulo NREQ.
  function automatic int model_winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- directed vector table ----------------
  // Requester i gets a = wa + i, b = wb, op = op. Checks happen mid-cycle,
  // before the edge that the row's inputs act on.
  typedef struct {
    logic [3:0]  valid;
    logic        rr;
    logic [63:0] wa;
    logic [63:0] wb;
    logic [3:0]  op;
    logic [3:0]  e_ready;
    logic [63:0] e_alu_a;
    logic [3:0]  e_ctl;
    logic        e_rv;
    logic [1:0]  e_id;
    logic [63:0] e_res;
    logic        e_zero;
  } vec_t;

  vec_t tbl[15];

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           m_ptr;
  logic         m_rv;
  logic [3:0]   ops[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                           4'b0111, 4'b1100, 4'b1111, 4'b1001};

  initial begin
    // single request to 2, then drain, zero flag, round-robin, backpressure,
    // undefined op code
    tbl[0]  = '{4'b0100, 1'b1, 64'd3,  64'd3, 4'b0010, 4'b0100, 64'd5,  4'b0010, 1'b0, 2'd0, 64'd0,  1'b0};
    tbl[1]  = '{4'b0000, 1'b0, 64'd0,  64'd0, 4'b0000, 4'b0000, 64'd0,  4'b0000, 1'b1, 2'd2, 64'd8,  1'b0};
    tbl[2]  = '{4'b0000, 1'b1, 64'd0,  64'd0, 4'b0000, 4'b0000, 64'd0,  4'b0000, 1'b1, 2'd2, 64'd8,  1'b0};
    tbl[3]  = '{4'b0001, 1'b1, 64'd7,  64'd7, 4'b0110, 4'b0001, 64'd7,  4'b0110, 1'b0, 2'd2, 64'd8,  1'b0};
    tbl[4]  = '{4'b1111, 1'b1, 64'd10, 64'd1, 4'b0010, 4'b0010, 64'd11, 4'b0010, 1'b1, 2'd0, 64'd0,  1'b1};
    tbl[5]  = '{4'b1111, 1'b1, 64'd10, 64'd1, 4'b0010, 4'b0100, 64'd12, 4'b0010, 1'b1, 2'd1, 64'd12, 1'b0};
    tbl[6]  = '{4'b1111, 1'b1, 64'd10, 64'd1, 4'b0010, 4'b1000, 64'd13, 4'b0010, 1'b1, 2'd2, 64'd13, 1'b0};
    tbl[7]  = '{4'b1111, 1'b1, 64'd10, 64'd1, 4'b0010, 4'b0001, 64'd10, 4'b0010, 1'b1, 2'd3, 64'd14, 1'b0};
    tbl[8]  = '{4'b1111, 1'b1, 64'd10, 64'd1, 4'b0010, 4'b0010, 64'd11, 4'b0010, 1'b1, 2'd0, 64'd11, 1'b0};
    tbl[9]  = '{4'b0011, 1'b0, 64'd10, 64'd1, 4'b0010, 4'b0000, 64'd0,  4'b0000, 1'b1, 2'd1, 64'd12, 1'b0};
    tbl[10] = '{4'b0011, 1'b0, 64'd10, 64'd1, 4'b0010, 4'b0000, 64'd0,  4'b0000, 1'b1, 2'd1, 64'd12, 1'b0};
    tbl[11] = '{4'b0011, 1'b1, 64'd10, 64'd1, 4'b0010, 4'b0001, 64'd10, 4'b0010, 1'b1, 2'd1, 64'd12, 1'b0};
    tbl[12] = '{4'b0000, 1'b1, 64'd0,  64'd0, 4'b0000, 4'b0000, 64'd0,  4'b0000, 1'b1, 2'd0, 64'd11, 1'b0};
    tbl[13] = '{4'b0010, 1'b1, 64'd0,  64'd0, 4'b1111, 4'b0010, 64'd1,  4'b1111, 1'b0, 2'd0, 64'd11, 1'b0};
    tbl[14] = '{4'b0000, 1'b0, 64'd0,  64'd0, 4'b0000, 4'b0000, 64'd0,  4'b0000, 1'b1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    // ---------------- reset ----------------
    reset     = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready",  64'(req_ready),  64'd0);
    chk("reset_rsp_valid",  64'(rsp_valid),  64'd0);
    chk("reset_rsp_id",     64'(rsp_id),     64'd0);
    chk("reset_rsp_result", rsp_result,      64'd0);
    chk("reset_rsp_zero",   64'(rsp_zero),   64'd0);
    chk("reset_alu_a",      alu_a,           64'd0);
    tick();
    reset = 1'b0;

    // ---------------- table ----------------
    for (int v = 0; v < 15; v++) begin
      rsp_ready = tbl[v].rr;
      for (int i = 0; i < NREQ; i++)
        set_req(i, tbl[v].valid[i], tbl[v].wa + 64'(i), tbl[v].wb, tbl[v].op);
      @(negedge clk);
      chk($sformatf("tbl%0d_req_ready", v),  64'(req_ready),  64'(tbl[v].e_ready));
      chk($sformatf("tbl%0d_alu_a", v),      alu_a,           tbl[v].e_alu_a);
      chk($sformatf("tbl%0d_alu_ctl", v),    64'(alu_ctl),    64'(tbl[v].e_ctl));
      chk($sformatf("tbl%0d_rsp_valid", v),  64'(rsp_valid),  64'(tbl[v].e_rv));
      chk($sformatf("tbl%0d_rsp_id", v),     64'(rsp_id),     64'(tbl[v].e_id));
      chk($sformatf("tbl%0d_rsp_result", v), rsp_result,      tbl[v].e_res);
      chk($sformatf("tbl%0d_rsp_zero", v),   64'(rsp_zero),   64'(tbl[v].e_zero));
      tick();
    end

    // ---------------- wrap and skip ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    set_req(2, 1'b1, 64'd5, 64'd3, 4'b0010);   // ptr 0 -> grant 2 -> ptr 3
    @(negedge clk);
    chk("wrap_first_grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    set_req(1, 1'b1, 64'd20, 64'd4, 4'b0110);  // ptr 3: scan 3,0,1 -> 1
    @(negedge clk);
    chk("wrap_grant_1", 64'(req_ready), 64'b0010);
    chk("wrap_alu_b",   alu_b,          64'd4);
    tick();
    chk("wrap_rsp_id_1",  64'(rsp_id),  64'd1);
    chk("wrap_rsp_res_1", rsp_result,   64'd16);
    set_req(0, 1'b1, 64'd9, 64'd9, 4'b0000);   // ptr 2: scan 2,3,0 -> 0
    set_req(1, 1'b1, 64'd20, 64'd4, 4'b0110);
    @(negedge clk);
    chk("wrap_grant_0", 64'(req_ready), 64'b0001);
    tick();
    chk("wrap_rsp_id_0",  64'(rsp_id),  64'd0);
    chk("wrap_rsp_res_0", rsp_result,   64'd9);

    // ---------------- async reset mid-stream ----------------
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("areset_pre_valid", 64'(rsp_valid), 64'd1);
    #2;
    reset     = 1'b1;
    req_valid = '1;
    #1;
    chk("areset_rsp_valid",  64'(rsp_valid), 64'd0);
    chk("areset_rsp_result", rsp_result,     64'd0);
    chk("areset_req_ready",  64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("areset_first_grant", 64'(req_ready), 64'b0001);
    tick();

    // ---------------- randomized run against the reference model ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_ptr = 0;
    m_rv  = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0, 4'b0000);
    rsp_ready = 1'b1;

    for (int c = 0; c < 400; c++) begin
      int          w;
      logic        can;
      logic [3:0]  e_ready;
      logic [N-1:0] ea, eb, er;
      logic [3:0]  eop;

      // stimulus: requesters that are idle or were just granted draw new work
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || (c == 0)) begin
          logic [N-1:0] ra;
          ra = {$urandom, $urandom};
          set_req(i, ($urandom_range(0, 99) < 55), ra,
                  ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom},
                  ops[$urandom_range(0, 7)]);
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);

      @(negedge clk);
      w   = model_winner(req_valid, m_ptr);
      can = !m_rv || rsp_ready;
      e_ready = '0;
      ea = '0; eb = '0; eop = 4'b0000;
      if (w >= 0 && can) begin
        e_ready[w] = 1'b1;
        ea  = req_a[w*N +: N];
        eb  = req_b[w*N +: N];
        eop = req_op[w*4 +: 4];
      end
      chk("rand_req_ready", 64'(req_ready), 64'(e_ready));
      chk("rand_alu_a",     alu_a,          ea);
      chk("rand_alu_b",     alu_b,          eb);
      chk("rand_alu_ctl",   64'(alu_ctl),   64'(eop));
      chk("rand_rsp_valid", 64'(rsp_valid), 64'(m_rv));
      if (m_rv && exp_q.size() > 0) begin
        chk("rand_rsp_id",     64'(rsp_id),   64'(exp_q[0][W-1 -: IDW]));
        chk("rand_rsp_result", rsp_result,    exp_q[0][N:1]);
        chk("rand_rsp_zero",   64'(rsp_zero), 64'(exp_q[0][0]));
      end

      tick();
      if (m_rv && rsp_ready) begin
        void'(exp_q.pop_front());
        m_rv = 1'b0;
      end
      if (w >= 0 && can) begin
        er = alu_fn(ea, eb, eop);
        exp_q.push_back({IDW'(w), er, (er == '0)});
        m_rv  = 1'b1;
        m_ptr = (w + 1) % NREQ;
        req_valid[w] = 1'b0;   // granted requester draws fresh work next cycle
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational 64-bit ALU between NREQ requesters (e.g. execute stage, address generator, debug port).
- Selects one valid request per cycle by round-robin and drives the ALU operand/control bus.
- Registers the ALU result, zero flag and requester ID into a single output stage with a valid/ready handshake.
- Sits between the requesters and the external ALU instance; contains no arithmetic of its own.

Parameters:
- N, 64, datapath width.
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of requester ID.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*N  operand A, requester i at bits [i*N +: N].
- req_b  input  NREQ*N  operand B, same packing.
- req_op  input  NREQ*4  ALU control code, requester i at bits [i*4 +: 4].
- req_ready  output  NREQ  one-hot grant; request i accepted when req_valid[i] & req_ready[i].
- alu_a  output  N  operand A to the shared ALU.
- alu_b  output  N  operand B to the shared ALU.
- alu_ctl  output  4  ALU control code to the shared ALU.
- alu_result  input  N  combinational result from the ALU.
- alu_zero  input  1  combinational zero flag from the ALU.
- rsp_valid  output  1  output stage holds a result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_result  output  N  registered result.
- rsp_zero  output  1  registered zero flag.

Behaviour:
- Reset (async, while asserted): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, priority pointer ptr=0. req_ready=0 while reset is high.
- can_accept = ~rsp_valid | rsp_ready. This is the output stage empty or draining this cycle.
- Arbitration is combinational within the cycle. Scan i = ptr, ptr+1, ..., wrapping modulo NREQ. The first i with req_valid[i]=1 is the winner.
- req_ready[winner]=1 only when can_accept. All other req_ready bits are 0. Grant is at most one-hot.
- When a winner exists and can_accept: alu_a/alu_b/alu_ctl = the winner's req_a/req_b/req_op.
- Otherwise alu_a=0, alu_b=0, alu_ctl=4'b0000.
- The ALU op code is passed through unmodified. Undefined codes still yield the ALU's all-ones result and are not filtered.
- On a clock edge with an accepted request:
  - rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_id <= winner, rsp_valid <= 1.
  - ptr <= (winner+1) mod NREQ.
- On an edge with rsp_valid & rsp_ready and no accept: rsp_valid <= 0. Data registers hold their old values.
- Simultaneous drain and accept (rsp_valid & rsp_ready & new grant): the new result replaces the old and rsp_valid stays 1. This gives full throughput of one op per cycle.
- Stall: rsp_valid & ~rsp_ready → no grant, ptr unchanged, and rsp_* stable until accepted.
- Latency: a request accepted at edge t has its response visible after edge t (one cycle).
- ptr changes only on an accept. With no valid requests, the state is unchanged.
- Fairness: a continuously asserted requester waits at most NREQ-1 grants.
- Requesters must hold req_* stable while valid and not granted. The arbiter does not latch unaccepted requests.
- Reset mid-operation: any pending response is discarded, ptr returns to 0, and the first grant after release follows requester 0 priority.
- Wrap-around: winner=NREQ-1 sets ptr=0.

Test Plan:
- Reset then a single request: req_valid=4'b0100, a=5, b=3, op=4'b0010 → req_ready=4'b0100. Next cycle: rsp_valid=1, rsp_id=2, rsp_result=8, rsp_zero=0.
- Zero flag: requester 0 with a=7, b=7, op=4'b0110 → rsp_result=0, rsp_zero=1.
- Round-robin: all four valid continuously with rsp_ready=1 → grants to IDs 0,1,2,3,0,1 on consecutive cycles, one response per cycle.
- Backpressure: rsp_ready=0 with a response held and req_valid=4'b0011 → req_ready=0, rsp_* unchanged, ptr unchanged. Raise rsp_ready → next grant goes to ptr's winner, with no lost or duplicated response.
- Wrap and skip: ptr=3, req_valid=4'b0010 → grant to 1, ptr becomes 2. Then req_valid=4'b0011 → grant to 0 after wrapping past 2 and 3.
- Async reset mid-stream: assert reset between edges while rsp_valid=1 → rsp_valid drops immediately without a clock edge. After release, with all four valid, the first grant goes to ID 0.
